// File: rtl/seg_pkg.sv
// Shared types and helpers for the 8-digit 7-segment scan sequencer.
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] COM_OFF    = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Digits 0..3 show the ciphertext and 4..7 the plaintext, most significant nibble first.
  function automatic logic [3:0] nibble_sel(input logic [2:0]  digit,
                                            input logic [15:0] en,
                                            input logic [15:0] pl);
    logic [15:0] word;
    word = digit[2] ? pl : en;
    case (digit[1:0])
      2'd0:    nibble_sel = word[15:12];
      2'd1:    nibble_sel = word[11:8];
      2'd2:    nibble_sel = word[7:4];
      default: nibble_sel = word[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seg_data_buffer.sv
// Pending/active double buffer. New data reaches the active copy only on a transfer.
module seg_data_buffer
  import seg_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        xfer,
  input  logic [15:0] en_in,
  input  logic [15:0] pl_in,
  output logic [15:0] act_en,
  output logic [15:0] act_pl,
  output logic        load_ack
);

  logic [15:0] pend_en_q, pend_en_d;
  logic [15:0] pend_pl_q, pend_pl_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] act_en_q, act_en_d;
  logic [15:0] act_pl_q, act_pl_d;
  logic        load_ack_q, load_ack_d;

  always_comb begin
    pend_en_d    = pend_en_q;
    pend_pl_d    = pend_pl_q;
    pend_valid_d = pend_valid_q;
    act_en_d     = act_en_q;
    act_pl_d     = act_pl_q;
    load_ack_d   = 1'b0;
    if (xfer) begin
      pend_valid_d = 1'b0;
      // A load coinciding with the transfer bypasses the pending copy.
      if (load) begin
        act_en_d   = en_in;
        act_pl_d   = pl_in;
        load_ack_d = 1'b1;
      end else if (pend_valid_q) begin
        act_en_d   = pend_en_q;
        act_pl_d   = pend_pl_q;
        load_ack_d = 1'b1;
      end
    end else if (load) begin
      pend_en_d    = en_in;
      pend_pl_d    = pl_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_en_q    <= '0;
      pend_pl_q    <= '0;
      pend_valid_q <= 1'b0;
      act_en_q     <= '0;
      act_pl_q     <= '0;
      load_ack_q   <= 1'b0;
    end else begin
      pend_en_q    <= pend_en_d;
      pend_pl_q    <= pend_pl_d;
      pend_valid_q <= pend_valid_d;
      act_en_q     <= act_en_d;
      act_pl_q     <= act_pl_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign act_en   = act_en_q;
  assign act_pl   = act_pl_q;
  assign load_ack = load_ack_q;

endmodule

// File: rtl/seg_scan_sequencer.sv
// Time-multiplexed scan of 8 digits with a blanking guard at the start of each slot.
module seg_scan_sequencer
  import seg_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] en_data,
  input  logic [15:0] pl_data,
  output logic [3:0]  Out,
  output logic [7:0]  com,
  output logic        frame_done,
  output logic        load_ack
);

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] CNT_BLANK = 16'(BLANK);

  state_e      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [15:0] cnt_q, cnt_d;
  logic        boundary, xfer;
  logic [15:0] act_en, act_pl;

  assign boundary = (state_q == SCAN) && (digit_q == 3'd7) && (cnt_q == CNT_LAST);
  // Transfers happen on scan start and on the closing edge of each frame.
  assign xfer     = enable && ((state_q == IDLE) || boundary);

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SCAN;
          digit_d = 3'd0;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!enable) begin
          state_d = IDLE;
          digit_d = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          digit_d = digit_q + 3'd1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      digit_q <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  seg_data_buffer u_buf (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .xfer     (xfer),
    .en_in    (en_data),
    .pl_in    (pl_data),
    .act_en   (act_en),
    .act_pl   (act_pl),
    .load_ack (load_ack)
  );

  always_comb begin
    Out = 4'd0;
    com = COM_OFF;
    if (state_q == SCAN) begin
      Out = nibble_sel(digit_q, act_en, act_pl);
      if (cnt_q >= CNT_BLANK)
        com = COM_OFF & ~(NUM_DIGITS'(1) << digit_q);
    end
  end

  assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Directed bench with a frame-position model checked every cycle, plus literal pins.
module tb_seg_scan_sequencer;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] en_data = 16'h0;
  logic [15:0] pl_data = 16'h0;
  logic [3:0]  Out;
  logic [7:0]  com;
  logic        frame_done;
  logic        load_ack;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  seg_scan_sequencer #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .en_data(en_data), .pl_data(pl_data), .Out(Out), .com(com),
    .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clock = ~clock;

  // Model: position t within the frame, plus active/pending copies.
  bit          scan_m = 1'b0;
  int          t = 0;
  logic [15:0] a_en = 16'h0, a_pl = 16'h0, p_en = 16'h0, p_pl = 16'h0;
  bit          pv = 1'b0;
  bit          ack_m = 1'b0;

  wire m_bound = scan_m && (t == FRAME - 1);
  wire m_xfer  = enable && (!scan_m || m_bound);

  always @(posedge clock) begin
    if (reset) begin
      scan_m <= 1'b0; t <= 0; pv <= 1'b0; ack_m <= 1'b0;
      a_en <= 16'h0; a_pl <= 16'h0; p_en <= 16'h0; p_pl <= 16'h0;
    end else begin
      if (m_xfer) begin
        if (load) begin a_en <= en_data; a_pl <= pl_data; end
        else if (pv) begin a_en <= p_en; a_pl <= p_pl; end
        pv    <= 1'b0;
        ack_m <= load || pv;
      end else begin
        ack_m <= 1'b0;
        if (load) begin p_en <= en_data; p_pl <= pl_data; pv <= 1'b1; end
      end
      if (!enable) begin scan_m <= 1'b0; t <= 0; end
      else if (!scan_m) begin scan_m <= 1'b1; t <= 0; end
      else t <= (t + 1) % FRAME;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin : compare
    int dg, cn;
    logic [15:0] w;
    int e_out, e_com;
    if (chk_en) begin
      dg = t / DIV;
      cn = t % DIV;
      w  = (dg < 4) ? a_en : a_pl;
      e_out = scan_m ? int'((w >> (4 * (3 - dg % 4))) & 16'hF) : 0;
      e_com = (scan_m && cn >= BLANK) ? int'(8'hFF & ~(8'd1 << dg)) : 8'hFF;
      chk("model_out", int'(Out), e_out);
      chk("model_com", int'(com), e_com);
      chk("model_frame_done", int'(frame_done), int'(m_bound));
      chk("model_load_ack", int'(load_ack), int'(ack_m));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [15:0] e, input logic [15:0] p);
    load = 1'b1; en_data = e; pl_data = p;
  endtask

  initial begin
    logic [3:0] seq_a [8];
    seq_a = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};

    step(2);
    chk_en = 1'b1;
    chk("reset_com", int'(com), 8'hFF);
    chk("reset_out", int'(Out), 0);
    chk("reset_fd", int'(frame_done), 0);
    chk("reset_ack", int'(load_ack), 0);

    // Frame 1: no data, check blanking and select pattern.
    reset = 1'b0; enable = 1'b1;
    step(1); chk("blank_d0", int'(com), 8'hFF);
    step(2); chk("sel_d0", int'(com), 8'hFE);
    step(61);
    chk("fd_boundary", int'(frame_done), 1);
    chk("sel_d7", int'(com), 8'h7F);
    step(1); chk("fd_clear", int'(frame_done), 0);

    // Frame 2: mid-frame load, must not show until next frame.
    step(10); do_load(16'h1234, 16'hABCD);
    step(1); load = 1'b0;
    chk("midframe_unchanged", int'(Out), 0);
    step(52); chk("ack_before_bound", int'(load_ack), 0);
    step(1); chk("ack_after_bound", int'(load_ack), 1);
    step(3); chk("seq_d0", int'(Out), int'(seq_a[0]));
    for (int k = 1; k < 8; k++) begin
      step(8); chk("seq_dk", int'(Out), int'(seq_a[k]));
    end

    // Two loads in one frame: the last one wins.
    step(1); do_load(16'h1111, 16'h2222);
    step(1); do_load(16'h5555, 16'h6666);
    step(1); load = 1'b0;
    step(2); chk("dbl_ack", int'(load_ack), 1);
    step(1); chk("dbl_ack_once", int'(load_ack), 0);
    step(2); chk("dbl_d0", int'(Out), 5);
    for (int k = 1; k < 8; k++) begin
      step(8); chk("dbl_dk", int'(Out), (k < 4) ? 5 : 6);
    end

    // Load in the boundary cycle bypasses straight to the next frame.
    step(4); chk("bnd_fd", int'(frame_done), 1);
    do_load(16'hF00F, 16'h0000);
    step(1); load = 1'b0;
    chk("bnd_ack", int'(load_ack), 1);
    chk("bnd_out", int'(Out), 4'hF);
    step(3); chk("bnd_d0", int'(Out), 4'hF);

    // Enable drop during digit 3, pending data shown after restart.
    do_load(16'h7777, 16'h8888);
    step(1); load = 1'b0;
    step(22);
    chk("drop_pre_com", int'(com), 8'hF7);
    chk("drop_pre_out", int'(Out), 4'hF);
    enable = 1'b0;
    step(1);
    chk("drop_com", int'(com), 8'hFF);
    chk("drop_out", int'(Out), 0);
    chk("drop_fd", int'(frame_done), 0);
    step(3); enable = 1'b1;
    step(1); chk("reen_ack", int'(load_ack), 1);
    step(3); chk("reen_d0", int'(Out), 7);
    step(32); chk("reen_d4", int'(Out), 8);

    // Reset during digit 5 discards pending data.
    do_load(16'h9999, 16'h9999);
    step(1); load = 1'b0;
    step(6); chk("rst_pre_com", int'(com), 8'hDF);
    reset = 1'b1;
    step(1);
    chk("rst_com", int'(com), 8'hFF);
    chk("rst_out", int'(Out), 0);
    reset = 1'b0;
    step(1);
    step(3); chk("rst_d0", int'(Out), 0);
    for (int k = 1; k < 8; k++) begin
      step(8); chk("rst_dk", int'(Out), 0);
    end

    step(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
